// File: rtl/regfile_mp.sv
// Multi-ported integer register file with per-register busy scoreboard.
// Register 0 reads as zero; writes and reserves aimed at it are discarded.
// Read ports are combinational and can optionally forward same-cycle writes.
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*XLEN-1:0]  rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  input  logic [NUM_WRITE-1:0]      wr_en,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next-state: retire writes in port order so the highest port wins, then apply the reserve last
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    busy_d = busy_q;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // State registers: reset clears all data and busy bits and overrides any write/reserve
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            busy;
    logic            hit;

    assign ra = rd_addr[i*AW +: AW];

    // Read port: registered value, optionally replaced by the highest-indexed matching write
    always_comb begin
      data = regs_q[ra];
      busy = busy_q[ra];
      hit  = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
            hit  = 1'b1;
            data = wr_data[j*XLEN +: XLEN];
          end
        end
        if (hit) begin
          busy = rsv_en && (rsv_addr == ra);
        end
      end
      if (ra == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = busy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one bypassing and one non-bypassing instance
// share the same stimulus; expected reads are queued per cycle and checked at negedge.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int NW   = 2;

  logic             clk;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*32-1:0] wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;

  logic [NR*XLEN-1:0] rd_data_byp;
  logic [NR-1:0]      rd_busy_byp;
  logic [NR*XLEN-1:0] rd_data_reg;
  logic [NR-1:0]      rd_busy_reg;

  int cycle;
  int tests;
  int fails;

  typedef struct {
    int          cyc;
    int          inst;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sb[$];

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_byp), .rd_busy(rd_busy_byp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(32), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(0)) dut_reg (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_reg), .rd_busy(rd_busy_reg),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to tag expectations with the cycle they belong to
  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Wait for the next edge, then return all inputs to idle; caller drives the rest
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    rd_addr  = '0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [31:0] d);
    wr_en[port]            = 1'b1;
    wr_addr[port*AW +: AW] = a;
    wr_data[port*32 +: 32] = d;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    rd_addr[port*AW +: AW] = a;
  endtask

  task automatic expectRead(input string name, input int inst, input int port,
                            input logic [31:0] d, input logic b);
    exp_t e;
    e.cyc  = cycle;
    e.inst = inst;
    e.port = port;
    e.data = d;
    e.busy = b;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic expectBoth(input string name, input int port, input logic [31:0] d, input logic b);
    expectRead(name, 0, port, d, b);
    expectRead(name, 1, port, d, b);
  endtask

  // Compare one queued expectation against the instance it names
  task automatic checkOutput(input exp_t e);
    logic [31:0] act_d;
    logic        act_b;
    if (e.inst == 0) begin
      act_d = rd_data_byp[e.port*32 +: 32];
      act_b = rd_busy_byp[e.port];
    end else begin
      act_d = rd_data_reg[e.port*32 +: 32];
      act_b = rd_busy_reg[e.port];
    end
    tests++;
    if (e.cyc != cycle || act_d !== e.data || act_b !== e.busy) begin
      fails++;
      $display("[TB] FAIL %s inst%0d port%0d cyc%0d/%0d: got data=%h busy=%b, expected data=%h busy=%b",
               e.name, e.inst, e.port, cycle, e.cyc, act_d, act_b, e.data, e.busy);
    end
  endtask

  // Monitor: reads are combinational, so every expectation is checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed stimulus
  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    rd_addr  = '0;

    // Reset state on every register, both ports
    for (int i = 0; i < 32; i++) begin
      applyStimulus();
      rd(0, AW'(i));
      rd(1, AW'(31 - i));
      expectBoth("reset_rd0", 0, 32'h0, 1'b0);
      expectBoth("reset_rd1", 1, 32'h0, 1'b0);
    end

    // Basic write, then write to register 0
    applyStimulus();
    wr(0, 5'd5, 32'hDEADBEEF);
    rd(0, 5'd5);
    expectRead("wr5_same", 0, 0, 32'hDEADBEEF, 1'b0);
    expectRead("wr5_same", 1, 0, 32'h0, 1'b0);
    applyStimulus();
    wr(0, 5'd0, 32'h1234);
    rd(0, 5'd5);
    rd(1, 5'd0);
    expectBoth("wr5_next", 0, 32'hDEADBEEF, 1'b0);
    expectBoth("wr0_same", 1, 32'h0, 1'b0);
    applyStimulus();
    rd(1, 5'd0);
    expectBoth("wr0_next", 1, 32'h0, 1'b0);

    // Bypass on read port 1
    applyStimulus();
    wr(0, 5'd7, 32'hA5A5A5A5);
    rd(1, 5'd7);
    expectRead("byp7_same", 0, 1, 32'hA5A5A5A5, 1'b0);
    expectRead("byp7_same", 1, 1, 32'h0, 1'b0);
    applyStimulus();
    rd(1, 5'd7);
    expectBoth("byp7_next", 1, 32'hA5A5A5A5, 1'b0);

    // Write conflict: highest port wins, in storage and on the bypass path
    applyStimulus();
    wr(0, 5'd9, 32'h11);
    wr(1, 5'd9, 32'h22);
    rd(0, 5'd9);
    expectRead("conf9_same", 0, 0, 32'h22, 1'b0);
    expectRead("conf9_same", 1, 0, 32'h0, 1'b0);
    applyStimulus();
    rd(0, 5'd9);
    expectBoth("conf9_next", 0, 32'h22, 1'b0);

    // Reserve / retire / reserve-with-write on register 3
    applyStimulus();
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    rd(0, 5'd3);
    expectBoth("rsv3_same", 0, 32'h0, 1'b0);
    applyStimulus();
    rd(0, 5'd3);
    expectBoth("rsv3_next", 0, 32'h0, 1'b1);
    applyStimulus();
    wr(0, 5'd3, 32'h33);
    rd(0, 5'd3);
    expectRead("ret3_same", 0, 0, 32'h33, 1'b0);
    expectRead("ret3_same", 1, 0, 32'h0, 1'b1);
    applyStimulus();
    rd(0, 5'd3);
    expectBoth("ret3_next", 0, 32'h33, 1'b0);
    applyStimulus();
    wr(1, 5'd3, 32'h44);
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    rd(0, 5'd3);
    expectRead("rsvwr3_same", 0, 0, 32'h44, 1'b1);
    expectRead("rsvwr3_same", 1, 0, 32'h33, 1'b0);
    applyStimulus();
    rd(0, 5'd3);
    expectBoth("rsvwr3_next", 0, 32'h44, 1'b1);

    // Reserving register 0 is dropped
    applyStimulus();
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    applyStimulus();
    rd(1, 5'd0);
    expectBoth("rsv0_next", 1, 32'h0, 1'b0);

    // Fill every register with 0x1000 + index using both write ports
    for (int k = 0; k < 16; k++) begin
      applyStimulus();
      wr(0, AW'(2*k + 1), 32'h1000 + 32'(2*k + 1));
      if (2*k + 2 <= 31) wr(1, AW'(2*k + 2), 32'h1000 + 32'(2*k + 2));
    end
    applyStimulus();
    rd(0, 5'd4);
    rd(1, 5'd31);
    expectBoth("fill4", 0, 32'h1004, 1'b0);
    expectBoth("fill31", 1, 32'h101F, 1'b0);
    applyStimulus();
    rsv_en   = 1'b1;
    rsv_addr = 5'd10;
    applyStimulus();
    rd(0, 5'd10);
    expectBoth("rsv10", 0, 32'h100A, 1'b1);

    // Reset with a simultaneous write: bypass still forwards, storage keeps old value this cycle
    applyStimulus();
    rst = 1'b1;
    wr(0, 5'd4, 32'hFFFF);
    rd(0, 5'd4);
    rd(1, 5'd10);
    expectRead("rstwr4_same", 0, 0, 32'hFFFF, 1'b0);
    expectRead("rstwr4_same", 1, 0, 32'h1004, 1'b0);
    expectBoth("rst10_same", 1, 32'h100A, 1'b1);

    // Everything cleared after reset, including the write issued during it
    for (int i = 0; i < 32; i++) begin
      applyStimulus();
      rd(0, AW'(i));
      rd(1, AW'(31 - i));
      expectBoth("post_rst_rd0", 0, 32'h0, 1'b0);
      expectBoth("post_rst_rd1", 1, 32'h0, 1'b0);
    end

    applyStimulus();
    repeat (3) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
